// File: rtl/aud_mode_ctrl_if.sv
// Key, address and command signals between the mode sequencer and the
// recorder/DSP/player datapath. The sequencer connects through the slave modport.
interface aud_mode_ctrl_if #(
  parameter int ADDR_W = 20
);
  logic              i_daclrck;
  logic              i_key_rec;
  logic              i_key_play;
  logic              i_key_pause;
  logic              i_key_stop;
  logic [ADDR_W-1:0] i_rec_addr;
  logic [ADDR_W-1:0] i_play_addr;
  logic              o_rec_start;
  logic              o_rec_pause;
  logic              o_rec_stop;
  logic              o_dsp_start;
  logic              o_dsp_pause;
  logic              o_dsp_stop;
  logic              o_player_en;
  logic [ADDR_W-1:0] o_end_addr;
  logic [2:0]        o_state;

  modport master (
    output i_daclrck, i_key_rec, i_key_play, i_key_pause, i_key_stop,
           i_rec_addr, i_play_addr,
    input  o_rec_start, o_rec_pause, o_rec_stop,
           o_dsp_start, o_dsp_pause, o_dsp_stop,
           o_player_en, o_end_addr, o_state
  );

  modport slave (
    input  i_daclrck, i_key_rec, i_key_play, i_key_pause, i_key_stop,
           i_rec_addr, i_play_addr,
    output o_rec_start, o_rec_pause, o_rec_stop,
           o_dsp_start, o_dsp_pause, o_dsp_stop,
           o_player_en, o_end_addr, o_state
  );
endinterface

// File: rtl/aud_mode_ctrl.sv
// Record/play mode sequencer: turns key pulses into one-cycle recorder/DSP
// commands, gates the I2S player on an LRCK rise and tracks the recording end.
module aud_mode_ctrl #(
  parameter int                ADDR_W   = 20,
  parameter logic [ADDR_W-1:0] MEM_LAST = 20'hFFFFF
) (
  input logic             i_clk,
  input logic             i_rst,
  aud_mode_ctrl_if.slave  ctrl
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_REC        = 3'd1,
    S_REC_PAUSE  = 3'd2,
    S_PLAY_WAIT  = 3'd3,
    S_PLAY       = 3'd4,
    S_PLAY_PAUSE = 3'd5
  } state_e;

  typedef struct packed {
    logic rec_start;
    logic rec_pause;
    logic rec_stop;
    logic dsp_start;
    logic dsp_pause;
    logic dsp_stop;
  } cmd_t;

  state_e            state_q, state_d;
  cmd_t              cmd_q, cmd_d;
  logic              player_en_q, player_en_d;
  logic [ADDR_W-1:0] end_addr_q, end_addr_d;
  logic              lrck_q;
  logic              lrck_rise;

  assign lrck_rise = ctrl.i_daclrck & ~lrck_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      cmd_q       <= '0;
      player_en_q <= 1'b0;
      end_addr_q  <= '0;
      lrck_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      player_en_q <= player_en_d;
      end_addr_q  <= end_addr_d;
      lrck_q      <= ctrl.i_daclrck;
    end
  end

  // Each state tests only its legal keys, in stop > pause > play > rec order;
  // the address-triggered stops rank below any legal key.
  always_comb begin
    state_d    = state_q;
    cmd_d      = '0;
    end_addr_d = end_addr_q;
    case (state_q)
      S_IDLE: begin
        if (ctrl.i_key_play && (end_addr_q != '0)) begin
          state_d         = S_PLAY_WAIT;
          cmd_d.dsp_start = 1'b1;
        end else if (ctrl.i_key_rec) begin
          state_d         = S_REC;
          cmd_d.rec_start = 1'b1;
        end
      end
      S_REC: begin
        if (ctrl.i_key_stop) begin
          state_d        = S_IDLE;
          cmd_d.rec_stop = 1'b1;
          end_addr_d     = ctrl.i_rec_addr;
        end else if (ctrl.i_key_pause) begin
          state_d         = S_REC_PAUSE;
          cmd_d.rec_pause = 1'b1;
        end else if (ctrl.i_rec_addr == MEM_LAST) begin
          state_d        = S_IDLE;
          cmd_d.rec_stop = 1'b1;
          end_addr_d     = ctrl.i_rec_addr;
        end
      end
      S_REC_PAUSE: begin
        if (ctrl.i_key_stop) begin
          state_d        = S_IDLE;
          cmd_d.rec_stop = 1'b1;
          end_addr_d     = ctrl.i_rec_addr;
        end else if (ctrl.i_key_pause || ctrl.i_key_rec) begin
          state_d         = S_REC;
          cmd_d.rec_start = 1'b1;
        end
      end
      S_PLAY_WAIT: begin
        if (ctrl.i_key_stop) begin
          state_d        = S_IDLE;
          cmd_d.dsp_stop = 1'b1;
        end else if (lrck_rise) begin
          state_d = S_PLAY;
        end
      end
      S_PLAY: begin
        if (ctrl.i_key_stop) begin
          state_d        = S_IDLE;
          cmd_d.dsp_stop = 1'b1;
        end else if (ctrl.i_key_pause) begin
          state_d         = S_PLAY_PAUSE;
          cmd_d.dsp_pause = 1'b1;
        end else if (ctrl.i_play_addr >= end_addr_q) begin
          state_d        = S_IDLE;
          cmd_d.dsp_stop = 1'b1;
        end
      end
      S_PLAY_PAUSE: begin
        if (ctrl.i_key_stop) begin
          state_d        = S_IDLE;
          cmd_d.dsp_stop = 1'b1;
        end else if (ctrl.i_key_pause || ctrl.i_key_play) begin
          state_d         = S_PLAY_WAIT;
          cmd_d.dsp_start = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Player enable is a registered image of "next state is PLAY", so it
    // rises on LRCK-gated entry and falls with the pause/stop pulse.
    player_en_d = (state_d == S_PLAY);
  end

  always_comb begin
    ctrl.o_rec_start = cmd_q.rec_start;
    ctrl.o_rec_pause = cmd_q.rec_pause;
    ctrl.o_rec_stop  = cmd_q.rec_stop;
    ctrl.o_dsp_start = cmd_q.dsp_start;
    ctrl.o_dsp_pause = cmd_q.dsp_pause;
    ctrl.o_dsp_stop  = cmd_q.dsp_stop;
    ctrl.o_player_en = player_en_q;
    ctrl.o_end_addr  = end_addr_q;
    ctrl.o_state     = state_q;
  end

endmodule

// File: tb/tb_aud_mode_ctrl.sv
// Scenario bench for aud_mode_ctrl: each step's expected outputs are queued
// as the stimulus is driven and popped for comparison after the clock edge.
module tb_aud_mode_ctrl;

  typedef struct packed {
    logic [2:0]  st;
    logic [5:0]  cmd;
    logic        pen;
    logic [19:0] ea;
  } exp_t;

  typedef struct packed {
    logic        rst;
    logic [3:0]  key;
    logic        lrck;
    logic [19:0] ra;
    logic [19:0] pa;
    exp_t        e;
  } step_t;

  localparam logic [3:0] K_NONE  = 4'b0000;
  localparam logic [3:0] K_REC   = 4'b1000;
  localparam logic [3:0] K_PLAY  = 4'b0100;
  localparam logic [3:0] K_PAUSE = 4'b0010;
  localparam logic [3:0] K_STOP  = 4'b0001;

  localparam logic [5:0] C_NONE = 6'b000000;
  localparam logic [5:0] C_RST  = 6'b100000;
  localparam logic [5:0] C_RPS  = 6'b010000;
  localparam logic [5:0] C_RSP  = 6'b001000;
  localparam logic [5:0] C_DST  = 6'b000100;
  localparam logic [5:0] C_DPS  = 6'b000010;
  localparam logic [5:0] C_DSP  = 6'b000001;

  logic clk = 1'b0;
  logic rst;
  int   tests_run = 0;
  int   tests_failed = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  aud_mode_ctrl_if #(.ADDR_W(20)) bus ();

  aud_mode_ctrl #(.ADDR_W(20), .MEM_LAST(20'hFFFFF)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .ctrl  (bus.slave)
  );

  function automatic step_t mk(input logic r, input logic [3:0] k, input logic l,
                               input logic [19:0] ra, input logic [19:0] pa,
                               input logic [2:0] st, input logic [5:0] cmd,
                               input logic pen, input logic [19:0] ea);
    step_t s;
    s.rst = r; s.key = k; s.lrck = l; s.ra = ra; s.pa = pa;
    s.e.st = st; s.e.cmd = cmd; s.e.pen = pen; s.e.ea = ea;
    return s;
  endfunction

  task automatic drive(input step_t s);
    @(negedge clk);
    rst             = s.rst;
    bus.i_key_rec   = s.key[3];
    bus.i_key_play  = s.key[2];
    bus.i_key_pause = s.key[1];
    bus.i_key_stop  = s.key[0];
    bus.i_daclrck   = s.lrck;
    bus.i_rec_addr  = s.ra;
    bus.i_play_addr = s.pa;
    sb.push_back(s.e);
  endtask

  function automatic exp_t observe();
    exp_t o;
    o.st  = bus.o_state;
    o.cmd = {bus.o_rec_start, bus.o_rec_pause, bus.o_rec_stop,
             bus.o_dsp_start, bus.o_dsp_pause, bus.o_dsp_stop};
    o.pen = bus.o_player_en;
    o.ea  = bus.o_end_addr;
    return o;
  endfunction

  task automatic test_reset();
    step_t s[$];
    exp_t  got, want;
    s.push_back(mk(1, K_NONE, 0, 0, 0, 0, C_NONE, 0, 0));
    s.push_back(mk(1, K_REC,  0, 0, 0, 0, C_NONE, 0, 0));
    s.push_back(mk(0, K_NONE, 0, 0, 0, 0, C_NONE, 0, 0));
    foreach (s[i]) begin
      drive(s[i]);
      @(posedge clk); #1;
      got = observe(); want = sb.pop_front(); tests_run++;
      if (got !== want) begin
        tests_failed++;
        $display("FAIL test_reset[%0d] got st=%0d cmd=%b en=%b end=%h, want st=%0d cmd=%b en=%b end=%h",
                 i, got.st, got.cmd, got.pen, got.ea, want.st, want.cmd, want.pen, want.ea);
      end
    end
  endtask

  task automatic test_play_empty();
    step_t s[$];
    exp_t  got, want;
    s.push_back(mk(0, K_PLAY, 0, 0, 0, 0, C_NONE, 0, 0));
    s.push_back(mk(0, K_NONE, 0, 0, 0, 0, C_NONE, 0, 0));
    s.push_back(mk(0, K_STOP | K_PAUSE, 0, 0, 0, 0, C_NONE, 0, 0));
    foreach (s[i]) begin
      drive(s[i]);
      @(posedge clk); #1;
      got = observe(); want = sb.pop_front(); tests_run++;
      if (got !== want) begin
        tests_failed++;
        $display("FAIL test_play_empty[%0d] got st=%0d cmd=%b en=%b end=%h, want st=%0d cmd=%b en=%b end=%h",
                 i, got.st, got.cmd, got.pen, got.ea, want.st, want.cmd, want.pen, want.ea);
      end
    end
  endtask

  task automatic test_record();
    step_t s[$];
    exp_t  got, want;
    s.push_back(mk(0, K_REC,  0, 20'h00100, 0, 1, C_RST,  0, 20'h0));
    s.push_back(mk(0, K_NONE, 0, 20'h00200, 0, 1, C_NONE, 0, 20'h0));
    s.push_back(mk(0, K_REC,  0, 20'h00300, 0, 1, C_NONE, 0, 20'h0));
    s.push_back(mk(0, K_STOP, 0, 20'h00400, 0, 0, C_RSP,  0, 20'h00400));
    s.push_back(mk(0, K_NONE, 0, 20'h00500, 0, 0, C_NONE, 0, 20'h00400));
    foreach (s[i]) begin
      drive(s[i]);
      @(posedge clk); #1;
      got = observe(); want = sb.pop_front(); tests_run++;
      if (got !== want) begin
        tests_failed++;
        $display("FAIL test_record[%0d] got st=%0d cmd=%b en=%b end=%h, want st=%0d cmd=%b en=%b end=%h",
                 i, got.st, got.cmd, got.pen, got.ea, want.st, want.cmd, want.pen, want.ea);
      end
    end
  endtask

  task automatic test_playback();
    step_t s[$];
    exp_t  got, want;
    s.push_back(mk(0, K_PLAY, 0, 0, 0, 3, C_DST, 0, 20'h00400));
    for (int i = 0; i < 20; i++)
      s.push_back(mk(0, K_NONE, 0, 0, 0, 3, C_NONE, 0, 20'h00400));
    s.push_back(mk(0, K_NONE, 1, 0, 0, 4, C_NONE, 1, 20'h00400));
    s.push_back(mk(0, K_PLAY, 1, 0, 20'h003FF, 4, C_NONE, 1, 20'h00400));
    s.push_back(mk(0, K_NONE, 0, 0, 20'h003FF, 4, C_NONE, 1, 20'h00400));
    s.push_back(mk(0, K_NONE, 1, 0, 20'h003FF, 4, C_NONE, 1, 20'h00400));
    s.push_back(mk(0, K_NONE, 1, 0, 20'h00400, 0, C_DSP,  0, 20'h00400));
    s.push_back(mk(0, K_NONE, 0, 0, 20'h00400, 0, C_NONE, 0, 20'h00400));
    foreach (s[i]) begin
      drive(s[i]);
      @(posedge clk); #1;
      got = observe(); want = sb.pop_front(); tests_run++;
      if (got !== want) begin
        tests_failed++;
        $display("FAIL test_playback[%0d] got st=%0d cmd=%b en=%b end=%h, want st=%0d cmd=%b en=%b end=%h",
                 i, got.st, got.cmd, got.pen, got.ea, want.st, want.cmd, want.pen, want.ea);
      end
    end
  endtask

  task automatic test_pause_autostop();
    step_t s[$];
    exp_t  got, want;
    s.push_back(mk(0, K_REC,   0, 20'h00010, 0, 1, C_RST,  0, 20'h00400));
    s.push_back(mk(0, K_PAUSE, 0, 20'h00011, 0, 2, C_RPS,  0, 20'h00400));
    s.push_back(mk(0, K_NONE,  0, 20'h00011, 0, 2, C_NONE, 0, 20'h00400));
    s.push_back(mk(0, K_PAUSE, 0, 20'h00011, 0, 1, C_RST,  0, 20'h00400));
    s.push_back(mk(0, K_NONE,  0, 20'h00020, 0, 1, C_NONE, 0, 20'h00400));
    s.push_back(mk(0, K_NONE,  0, 20'hFFFFF, 0, 0, C_RSP,  0, 20'hFFFFF));
    s.push_back(mk(0, K_NONE,  0, 20'hFFFFF, 0, 0, C_NONE, 0, 20'hFFFFF));
    s.push_back(mk(0, K_NONE,  0, 20'h00000, 0, 0, C_NONE, 0, 20'hFFFFF));
    foreach (s[i]) begin
      drive(s[i]);
      @(posedge clk); #1;
      got = observe(); want = sb.pop_front(); tests_run++;
      if (got !== want) begin
        tests_failed++;
        $display("FAIL test_pause_autostop[%0d] got st=%0d cmd=%b en=%b end=%h, want st=%0d cmd=%b en=%b end=%h",
                 i, got.st, got.cmd, got.pen, got.ea, want.st, want.cmd, want.pen, want.ea);
      end
    end
  endtask

  task automatic test_play_pause();
    step_t s[$];
    exp_t  got, want;
    s.push_back(mk(0, K_PLAY,           0, 0, 0, 3, C_DST,  0, 20'hFFFFF));
    s.push_back(mk(0, K_NONE,           1, 0, 0, 4, C_NONE, 1, 20'hFFFFF));
    s.push_back(mk(0, K_PAUSE | K_STOP, 1, 0, 0, 0, C_DSP,  0, 20'hFFFFF));
    s.push_back(mk(0, K_PLAY,           0, 0, 0, 3, C_DST,  0, 20'hFFFFF));
    s.push_back(mk(0, K_NONE,           1, 0, 0, 4, C_NONE, 1, 20'hFFFFF));
    s.push_back(mk(0, K_PAUSE,          1, 0, 0, 5, C_DPS,  0, 20'hFFFFF));
    s.push_back(mk(0, K_NONE,           0, 0, 0, 5, C_NONE, 0, 20'hFFFFF));
    s.push_back(mk(0, K_PLAY,           0, 0, 0, 3, C_DST,  0, 20'hFFFFF));
    s.push_back(mk(0, K_PAUSE,          0, 0, 0, 3, C_NONE, 0, 20'hFFFFF));
    s.push_back(mk(0, K_NONE,           1, 0, 0, 4, C_NONE, 1, 20'hFFFFF));
    foreach (s[i]) begin
      drive(s[i]);
      @(posedge clk); #1;
      got = observe(); want = sb.pop_front(); tests_run++;
      if (got !== want) begin
        tests_failed++;
        $display("FAIL test_play_pause[%0d] got st=%0d cmd=%b en=%b end=%h, want st=%0d cmd=%b en=%b end=%h",
                 i, got.st, got.cmd, got.pen, got.ea, want.st, want.cmd, want.pen, want.ea);
      end
    end
  endtask

  task automatic test_reset_mid();
    step_t s[$];
    exp_t  got, want;
    s.push_back(mk(1, K_NONE,  1, 0, 0, 0, C_NONE, 0, 20'h0));
    s.push_back(mk(0, K_NONE,  1, 0, 0, 0, C_NONE, 0, 20'h0));
    s.push_back(mk(0, K_PLAY,  1, 0, 0, 0, C_NONE, 0, 20'h0));
    s.push_back(mk(0, K_REC,   0, 20'h00033, 0, 1, C_RST, 0, 20'h0));
    s.push_back(mk(0, K_PAUSE, 0, 20'h00040, 0, 2, C_RPS, 0, 20'h0));
    s.push_back(mk(0, K_STOP,  0, 20'h00044, 0, 0, C_RSP, 0, 20'h00044));
    foreach (s[i]) begin
      drive(s[i]);
      @(posedge clk); #1;
      got = observe(); want = sb.pop_front(); tests_run++;
      if (got !== want) begin
        tests_failed++;
        $display("FAIL test_reset_mid[%0d] got st=%0d cmd=%b en=%b end=%h, want st=%0d cmd=%b en=%b end=%h",
                 i, got.st, got.cmd, got.pen, got.ea, want.st, want.cmd, want.pen, want.ea);
      end
    end
  endtask

  initial begin
    rst             = 1'b1;
    bus.i_daclrck   = 1'b0;
    bus.i_key_rec   = 1'b0;
    bus.i_key_play  = 1'b0;
    bus.i_key_pause = 1'b0;
    bus.i_key_stop  = 1'b0;
    bus.i_rec_addr  = '0;
    bus.i_play_addr = '0;
    test_reset();
    test_play_empty();
    test_record();
    test_playback();
    test_pause_autostop();
    test_play_pause();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
